// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: shared types and encodings for the multi-cycle control unit.
//   state_t  - control FSM states
//   iclass_t - decoded instruction class
//   ctrl_t   - bundle of Moore control outputs
//   OP_*, ALU_*, SRCB_*, PC_* - opcode and datapath select encodings
//   *_LSB    - IR field bit positions
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_WB_ALU, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        CLS_R, CLS_I, CLS_LW, CLS_SW, CLS_BR, CLS_J, CLS_HALT, CLS_ILL
    } iclass_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BNE  = 4'h5;
    localparam logic [3:0] OP_J    = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [2:0] ALU_FUNCT = 3'd2;
    localparam logic [2:0] ALU_PASSB = 3'd3;

    localparam logic [1:0] SRCB_REG = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam int OPC_LSB = 12;
    localparam int RD_LSB  = 9;
    localparam int RS_LSB  = 6;
    localparam int RT_LSB  = 3;
    // BEQ/BNE differ only in opcode bit 0, which inverts the branch condition
    localparam int NE_BIT  = 12;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       reg_write;
        logic       mem_to_reg;
        logic       branch;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctrl_t;

endpackage

// File: rtl/mc_control_fsm_if.sv
// mc_control_fsm_if: memory request/ready handshake between control unit and memory.
//   master (control unit): drives mem_req, mem_we, iord; samples mem_rdata, mem_ready
//   slave  (memory side):  the reverse
interface mc_control_fsm_if #(parameter int WORD_W = 16);
    logic              mem_req;
    logic              mem_we;
    logic              iord;
    logic              mem_ready;
    logic [WORD_W-1:0] mem_rdata;
    modport master (output mem_req, mem_we, iord, input mem_rdata, mem_ready);
    modport slave  (input mem_req, mem_we, iord, output mem_rdata, mem_ready);
endinterface

// File: rtl/mc_decode.sv
// mc_decode: combinational opcode to instruction-class decode.
//   opcode - IR[15:12]
//   iclass - instruction class; unknown opcodes map to CLS_ILL
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [3:0] opcode,
    output iclass_t    iclass
);
    assign iclass = (opcode == OP_R)                         ? CLS_R    :
                    (opcode == OP_ADDI)                      ? CLS_I    :
                    (opcode == OP_LW)                        ? CLS_LW   :
                    (opcode == OP_SW)                        ? CLS_SW   :
                    (opcode == OP_BEQ || opcode == OP_BNE)   ? CLS_BR   :
                    (opcode == OP_J)                         ? CLS_J    :
                    (opcode == OP_HALT)                      ? CLS_HALT :
                                                               CLS_ILL;
endmodule

// File: rtl/mc_control_fsm.sv
// mc_control_fsm: multi-cycle control unit for the 16-bit processor.
//   CLK, RST_N        - clock, async active-low reset
//   bus (master)      - memory handshake: mem_req/mem_we/iord out, mem_rdata/mem_ready in
//   alu_zero          - ALU zero flag, used in BRANCH
//   ir_out, reg_*     - latched instruction and register file addresses/strobe
//   memToReg, branch, alu_*, pc_* - datapath controls
//   halted            - core stopped
//   MC_PERF_COUNTERS_EN adds cycle_count / instr_count outputs.
// Control outputs are registered from the next state, so they line up with
// state_q; only pc_write is combinational because it gates on mem_ready/alu_zero.
module mc_control_fsm
    import mc_ctrl_pkg::*;
#(
    parameter int WORD_W = 16,
    parameter int REG_AW = 3
)
(
    input  logic                CLK,
    input  logic                RST_N,
    mc_control_fsm_if.master    bus,
    input  logic                alu_zero,
    output logic [WORD_W-1:0]   ir_out,
    output logic [REG_AW-1:0]   reg_readA_address,
    output logic [REG_AW-1:0]   reg_readB_address,
    output logic [REG_AW-1:0]   reg_write_address,
    output logic                reg_write,
    output logic                memToReg,
    output logic                branch,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_op,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                halted
`ifdef MC_PERF_COUNTERS_EN
    ,
    output logic [31:0]         cycle_count,
    output logic [31:0]         instr_count
`endif
);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    ctrl_t             ctrl_q, ctrl_d;
    iclass_t           iclass;

    mc_decode u_decode (
        .opcode (ir_q[OPC_LSB +: 4]),
        .iclass (iclass)
    );

    function automatic ctrl_t ctrl_of(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_req = 1'b1; c.alu_src_b = SRCB_ONE; c.alu_op = ALU_ADD; c.pc_src = PC_ALU; end
            S_DECODE:   begin c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
            S_EXEC_R:   begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_FUNCT; end
            S_EXEC_I,
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; c.alu_op = ALU_ADD; end
            S_WB_ALU:   c.reg_write = 1'b1;
            S_MEM_RD:   begin c.mem_req = 1'b1; c.iord = 1'b1; end
            S_WB_MEM:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_req = 1'b1; c.mem_we = 1'b1; c.iord = 1'b1; end
            S_BRANCH:   begin c.branch = 1'b1; c.alu_src_a = 1'b1; c.alu_src_b = SRCB_REG; c.alu_op = ALU_SUB; c.pc_src = PC_ALUOUT; end
            S_JUMP:     c.pc_src = PC_JUMP;
            S_HALT:     c.halted = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE:     state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) begin
                            state_d = S_DECODE;
                            ir_d    = bus.mem_rdata;
                        end
            S_DECODE:   state_d = (iclass == CLS_R)                      ? S_EXEC_R   :
                                  (iclass == CLS_I)                      ? S_EXEC_I   :
                                  (iclass == CLS_LW || iclass == CLS_SW) ? S_MEM_ADDR :
                                  (iclass == CLS_BR)                     ? S_BRANCH   :
                                  (iclass == CLS_J)                      ? S_JUMP     :
                                  (iclass == CLS_HALT)                   ? S_HALT     :
                                                                           S_FETCH;
            S_EXEC_R,
            S_EXEC_I:   state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (iclass == CLS_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_WB_MEM;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_FETCH;
        endcase
        ctrl_d = ctrl_of(state_d);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign pc_write = (state_q == S_FETCH  && bus.mem_ready) ||
                      (state_q == S_BRANCH && (alu_zero ^ ir_q[NE_BIT])) ||
                      (state_q == S_JUMP);

    assign bus.mem_req        = ctrl_q.mem_req;
    assign bus.mem_we         = ctrl_q.mem_we;
    assign bus.iord           = ctrl_q.iord;
    assign reg_write          = ctrl_q.reg_write;
    assign memToReg           = ctrl_q.mem_to_reg;
    assign branch             = ctrl_q.branch;
    assign alu_src_a          = ctrl_q.alu_src_a;
    assign alu_src_b          = ctrl_q.alu_src_b;
    assign alu_op             = ctrl_q.alu_op;
    assign pc_src             = ctrl_q.pc_src;
    assign halted             = ctrl_q.halted;
    assign ir_out             = ir_q;
    assign reg_readA_address  = ir_q[RS_LSB +: REG_AW];
    assign reg_readB_address  = ir_q[RT_LSB +: REG_AW];
    assign reg_write_address  = ir_q[RD_LSB +: REG_AW];

`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_q, cycle_d, instr_q, instr_d;

    always_comb begin
        cycle_d = (state_q != S_IDLE && state_q != S_HALT) ? cycle_q + 32'd1 : cycle_q;
        instr_d = (state_q == S_FETCH && bus.mem_ready) ? instr_q + 32'd1 : instr_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            cycle_q <= cycle_d;
            instr_q <= instr_d;
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`endif

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb_mc_control_fsm: directed self-checking bench for mc_control_fsm.
module tb_mc_control_fsm;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        alu_zero = 1'b0;
    logic [15:0] ir_out;
    logic [2:0]  reg_readA_address, reg_readB_address, reg_write_address;
    logic        reg_write, memToReg, branch, alu_src_a, pc_write, halted;
    logic [1:0]  alu_src_b, pc_src;
    logic [2:0]  alu_op;
`ifdef MC_PERF_COUNTERS_EN
    logic [31:0] cycle_count, instr_count;
`endif
    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    mc_control_fsm_if #(.WORD_W(16)) mif ();

    mc_control_fsm #(.WORD_W(16), .REG_AW(3)) dut (
        .CLK               (CLK),
        .RST_N             (RST_N),
        .bus               (mif),
        .alu_zero          (alu_zero),
        .ir_out            (ir_out),
        .reg_readA_address (reg_readA_address),
        .reg_readB_address (reg_readB_address),
        .reg_write_address (reg_write_address),
        .reg_write         (reg_write),
        .memToReg          (memToReg),
        .branch            (branch),
        .alu_src_a         (alu_src_a),
        .alu_src_b         (alu_src_b),
        .alu_op            (alu_op),
        .pc_write          (pc_write),
        .pc_src            (pc_src),
        .halted            (halted)
`ifdef MC_PERF_COUNTERS_EN
        ,
        .cycle_count       (cycle_count),
        .instr_count       (instr_count)
`endif
    );

    // {mem_req, mem_we, iord, reg_write, memToReg, branch, alu_src_a, alu_src_b, alu_op, pc_src, halted}
    logic [14:0] obs;
    assign obs = {mif.mem_req, mif.mem_we, mif.iord, reg_write, memToReg, branch,
                  alu_src_a, alu_src_b, alu_op, pc_src, halted};

    localparam logic [14:0] E_IDLE     = 15'd0;
    localparam logic [14:0] E_FETCH    = {7'b1000000, 2'd1, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_DECODE   = {7'b0000000, 2'd2, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_EXEC_R   = {7'b0000001, 2'd0, 3'd2, 2'd0, 1'b0};
    localparam logic [14:0] E_EXEC_I   = {7'b0000001, 2'd2, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_MEM_ADDR = {7'b0000001, 2'd2, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_WB_ALU   = {7'b0001000, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_MEM_RD   = {7'b1010000, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_WB_MEM   = {7'b0001100, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_MEM_WR   = {7'b1110000, 2'd0, 3'd0, 2'd0, 1'b0};
    localparam logic [14:0] E_BRANCH   = {7'b0000011, 2'd0, 3'd1, 2'd1, 1'b0};
    localparam logic [14:0] E_JUMP     = {7'b0000000, 2'd0, 3'd0, 2'd2, 1'b0};
    localparam logic [14:0] E_HALT     = 15'd1;

    task automatic test_reset;
        RST_N = 1'b0;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 16'h0;
        alu_zero = 1'b0;
        repeat (2) @(negedge CLK);
        tests++;
        if (obs !== E_IDLE || pc_write !== 1'b0 || ir_out !== 16'h0) begin
            fails++;
            $display("FAIL reset_state: ctrl=%h pcw=%b ir=%h want ctrl=%h pcw=0 ir=0000", obs, pc_write, ir_out, E_IDLE);
        end
        RST_N = 1'b1;
        @(negedge CLK);
        tests++;
        if (obs !== E_FETCH) begin
            fails++;
            $display("FAIL idle_to_fetch: ctrl=%h want %h", obs, E_FETCH);
        end
    endtask

    task automatic test_rtype;
        logic [14:0] e [4] = '{E_FETCH, E_DECODE, E_EXEC_R, E_WB_ALU};
        logic        pw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        mif.mem_rdata = 16'h0458;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL rtype_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            if (i == 3) begin
                tests++;
                if ({reg_write_address, reg_readA_address, reg_readB_address, ir_out} !== {3'd2, 3'd1, 3'd3, 16'h0458}) begin
                    fails++;
                    $display("FAIL rtype_fields: rd=%0d rs=%0d rt=%0d ir=%h want rd=2 rs=1 rt=3 ir=0458",
                             reg_write_address, reg_readA_address, reg_readB_address, ir_out);
                end
            end
            @(negedge CLK);
        end
        tests++;
        if (obs !== E_FETCH) begin
            fails++;
            $display("FAIL rtype_end: ctrl=%h want %h", obs, E_FETCH);
        end
    endtask

    task automatic test_addi;
        logic [14:0] e [4] = '{E_FETCH, E_DECODE, E_EXEC_I, E_WB_ALU};
        logic        pw [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        mif.mem_rdata = 16'h1E7F;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL addi_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        tests++;
        if (obs !== E_FETCH || reg_write_address !== 3'd7) begin
            fails++;
            $display("FAIL addi_end: ctrl=%h rd=%0d want ctrl=%h rd=7", obs, reg_write_address, E_FETCH);
        end
    endtask

    task automatic test_lw_wait;
        logic [14:0] e [8] = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_MEM_RD, E_WB_MEM};
        logic        pw [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        mif.mem_rdata = 16'h2A42;
        for (int i = 0; i < 8; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL lw_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        tests++;
        if (obs !== E_FETCH || reg_write_address !== 3'd5) begin
            fails++;
            $display("FAIL lw_end: ctrl=%h rd=%0d want ctrl=%h rd=5", obs, reg_write_address, E_FETCH);
        end
    endtask

    task automatic test_sw_fetch_wait;
        logic [14:0] e [6] = '{E_FETCH, E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WR, E_MEM_WR};
        logic        pw [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        rdy [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        mif.mem_rdata = 16'h3000;
        for (int i = 0; i < 6; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL sw_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        tests++;
        if (obs !== E_FETCH || ir_out !== 16'h3000) begin
            fails++;
            $display("FAIL sw_end: ctrl=%h ir=%h want ctrl=%h ir=3000", obs, ir_out, E_FETCH);
        end
    endtask

    task automatic test_branch;
        logic [15:0] ins  [4] = '{16'h4008, 16'h4008, 16'h5008, 16'h5008};
        logic        z    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic        take [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        logic [14:0] e    [3] = '{E_FETCH, E_DECODE, E_BRANCH};
        mif.mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            mif.mem_rdata = ins[k];
            alu_zero = z[k];
            for (int i = 0; i < 3; i++) begin
                #1;
                tests++;
                if (obs !== e[i] || pc_write !== (i == 0 ? 1'b1 : i == 2 ? take[k] : 1'b0)) begin
                    fails++;
                    $display("FAIL branch%0d_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", k, i, obs, pc_write,
                             e[i], (i == 0 ? 1'b1 : i == 2 ? take[k] : 1'b0));
                end
                @(negedge CLK);
            end
            tests++;
            if (obs !== E_FETCH) begin
                fails++;
                $display("FAIL branch%0d_end: ctrl=%h want %h", k, obs, E_FETCH);
            end
        end
        alu_zero = 1'b0;
    endtask

    task automatic test_jump;
        logic [14:0] e [3] = '{E_FETCH, E_DECODE, E_JUMP};
        logic        pw [3] = '{1'b1, 1'b0, 1'b1};
        mif.mem_rdata = 16'h6123;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL jump_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        tests++;
        if (obs !== E_FETCH) begin
            fails++;
            $display("FAIL jump_end: ctrl=%h want %h", obs, E_FETCH);
        end
    endtask

    task automatic test_illegal;
        logic [14:0] e [3] = '{E_FETCH, E_DECODE, E_FETCH};
        logic        pw [3] = '{1'b1, 1'b0, 1'b0};
        logic        rdy [3] = '{1'b1, 1'b1, 1'b0};
        mif.mem_rdata = 16'hA000;
        for (int i = 0; i < 3; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL illegal_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        mif.mem_ready = 1'b1;
    endtask

    task automatic test_halt;
        logic [14:0] e [2] = '{E_FETCH, E_DECODE};
        logic        pw [2] = '{1'b1, 1'b0};
        int          bad = 0;
        mif.mem_rdata = 16'hF000;
        mif.mem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            tests++;
            if (obs !== e[i] || pc_write !== pw[i]) begin
                fails++;
                $display("FAIL halt_cyc%0d: ctrl=%h pcw=%b want ctrl=%h pcw=%b", i, obs, pc_write, e[i], pw[i]);
            end
            @(negedge CLK);
        end
        for (int i = 0; i < 20; i++) begin
            mif.mem_ready = i[0];
            alu_zero = i[1];
            #1;
            if (obs !== E_HALT || pc_write !== 1'b0) bad++;
            @(negedge CLK);
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL halt_hold: %0d of 20 cycles left HALT, want 0", bad);
        end
        RST_N = 1'b0;
        #1;
        tests++;
        if (obs !== E_IDLE || halted !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset: ctrl=%h halted=%b want ctrl=%h halted=0", obs, halted, E_IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        mif.mem_ready = 1'b1;
        @(negedge CLK);
        tests++;
        if (obs !== E_FETCH || ir_out !== 16'h0) begin
            fails++;
            $display("FAIL halt_restart: ctrl=%h ir=%h want ctrl=%h ir=0000", obs, ir_out, E_FETCH);
        end
    endtask

    task automatic test_reset_mid_write;
        logic [14:0] e [4] = '{E_FETCH, E_DECODE, E_MEM_ADDR, E_MEM_WR};
        logic        rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b0};
        mif.mem_rdata = 16'h3000;
        for (int i = 0; i < 4; i++) begin
            mif.mem_ready = rdy[i];
            #1;
            tests++;
            if (obs !== e[i]) begin
                fails++;
                $display("FAIL rstwr_cyc%0d: ctrl=%h want %h", i, obs, e[i]);
            end
            if (i < 3) @(negedge CLK);
        end
        RST_N = 1'b0;
        #1;
        tests++;
        if (mif.mem_req !== 1'b0 || obs !== E_IDLE) begin
            fails++;
            $display("FAIL rstwr_async: mem_req=%b ctrl=%h want mem_req=0 ctrl=%h", mif.mem_req, obs, E_IDLE);
        end
        @(negedge CLK);
        RST_N = 1'b1;
        @(negedge CLK);
        tests++;
        if (obs !== E_FETCH) begin
            fails++;
            $display("FAIL rstwr_restart: ctrl=%h want %h", obs, E_FETCH);
        end
    endtask

    initial begin
        test_reset;
        test_rtype;
        test_addi;
        test_lw_wait;
        test_sw_fetch_wait;
        test_branch;
        test_jump;
        test_illegal;
        test_halt;
        test_reset_mid_write;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
